// File: rtl/fetcher_icache.sv
// Instruction fetcher with a 128-line direct-mapped I-cache (one 32-bit word per line).
// Latency: a hit delivers on the next edge; a miss issues one memory request and delivers on the response edge.
// Backpressure: in_stall blocks both delivery and new requests; rdy=0 freezes all state and outputs.
module fetcher_icache (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_rob_xbp,
    input  logic [31:0] in_rob_newpc,
    input  logic        in_stall,
    output logic        out_mem_flag,
    output logic [31:0] out_mem_addr,
    input  logic        in_mem_flag,
    input  logic [31:0] in_mem_data,
    output logic        out_inst_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    typedef enum logic {
        FETCH = 1'b0,
        MISS  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;

    // Cache storage: valid bits are reset, tag/data only matter once valid.
    logic [127:0] line_valid;
    logic [8:0]   line_tag  [128];
    logic [31:0]  line_data [128];

    logic [6:0]  idx;
    logic [8:0]  tag;
    logic        hit;

    logic        fill_en;
    logic        mem_flag_nxt;
    logic [31:0] mem_addr_nxt;
    logic        inst_valid_nxt;
    logic [31:0] inst_nxt;
    logic [31:0] out_pc_nxt;

    assign idx = pc[8:2];
    assign tag = pc[17:9];

    // Lookup is purely combinational off the current pc.
    assign hit = line_valid[idx] && (line_tag[idx] == tag);

    // Next-state and output decode; a flush overrides every other event.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        mem_flag_nxt   = 1'b0;
        mem_addr_nxt   = out_mem_addr;
        inst_valid_nxt = 1'b0;
        inst_nxt       = out_inst;
        out_pc_nxt     = out_pc;
        fill_en        = 1'b0;
        if (in_rob_xbp) begin
            pc_nxt    = in_rob_newpc;
            state_nxt = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (!in_stall) begin
                        if (hit) begin
                            inst_valid_nxt = 1'b1;
                            inst_nxt       = line_data[idx];
                            out_pc_nxt     = pc;
                            pc_nxt         = pc + 32'd4;
                        end else begin
                            mem_flag_nxt = 1'b1;
                            mem_addr_nxt = pc;
                            state_nxt    = MISS;
                        end
                    end
                end
                MISS: begin
                    // pc still holds the missed address, so idx/tag address the fill.
                    if (in_mem_flag) begin
                        fill_en   = 1'b1;
                        state_nxt = FETCH;
                        if (!in_stall) begin
                            inst_valid_nxt = 1'b1;
                            inst_nxt       = in_mem_data;
                            out_pc_nxt     = pc;
                            pc_nxt         = pc + 32'd4;
                        end
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else if (rdy) begin
            state <= state_nxt;
        end
    end

    // PC and registered outputs; everything holds while rdy is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc             <= 32'd0;
            out_mem_flag   <= 1'b0;
            out_mem_addr   <= 32'd0;
            out_inst_valid <= 1'b0;
            out_inst       <= 32'd0;
            out_pc         <= 32'd0;
        end else if (rdy) begin
            pc             <= pc_nxt;
            out_mem_flag   <= mem_flag_nxt;
            out_mem_addr   <= mem_addr_nxt;
            out_inst_valid <= inst_valid_nxt;
            out_inst       <= inst_nxt;
            out_pc         <= out_pc_nxt;
        end
    end

    // Valid bits: cleared by reset only, never by a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_valid <= '0;
        end else if (rdy && fill_en) begin
            line_valid[idx] <= 1'b1;
        end
    end

    // Tag and data arrays written on a fill.
    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_en) begin
            line_tag[idx]  <= tag;
            line_data[idx] <= in_mem_data;
        end
    end

endmodule

// File: tb/tb_fetcher_icache.sv
// Directed bench for fetcher_icache with request/delivery scoreboards.
// Expected memory requests and deliveries are queued as stimulus is applied and checked by a negedge monitor.
// Memory responses are driven explicitly by the directed sequence.
module tb_fetcher_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        in_rob_xbp = 1'b0;
    logic [31:0] in_rob_newpc = 32'd0;
    logic        in_stall = 1'b1;
    logic        out_mem_flag;
    logic [31:0] out_mem_addr;
    logic        in_mem_flag = 1'b0;
    logic [31:0] in_mem_data = 32'd0;
    logic        out_inst_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    fetcher_icache dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .in_rob_xbp     (in_rob_xbp),
        .in_rob_newpc   (in_rob_newpc),
        .in_stall       (in_stall),
        .out_mem_flag   (out_mem_flag),
        .out_mem_addr   (out_mem_addr),
        .in_mem_flag    (in_mem_flag),
        .in_mem_data    (in_mem_data),
        .out_inst_valid (out_inst_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] DA = 32'h00000013;
    localparam logic [31:0] DB = 32'h00100093;
    localparam logic [31:0] DC = 32'h00200113;
    localparam logic [31:0] DD = 32'h0aa00193;
    localparam logic [31:0] DE = 32'h00500213;
    localparam logic [31:0] DF = 32'h00600293;
    localparam logic [31:0] DG = 32'h00700313;
    localparam logic [31:0] DH = 32'h00800393;

    int vectors = 0;
    int miscompares = 0;
    int req_cnt = 0;
    int dlv_cnt = 0;
    int n_req_exp = 0;
    int n_dlv_exp = 0;

    logic [31:0] exp_req_q [$];
    logic [63:0] exp_dlv_q [$];
    logic        rdy_q = 1'b0;

    always @(posedge clk) rdy_q <= rdy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: pops one expectation per pulse produced by an enabled edge.
    always @(negedge clk) begin
        if (!rst && rdy_q) begin
            if (out_mem_flag) begin
                req_cnt++;
                if (exp_req_q.size() == 0) begin
                    check("unexpected_req", out_mem_addr, 32'hffff_ffff ^ out_mem_addr);
                end else begin
                    check("req_addr", out_mem_addr, exp_req_q.pop_front());
                end
            end
            if (out_inst_valid) begin
                dlv_cnt++;
                if (exp_dlv_q.size() == 0) begin
                    check("unexpected_dlv_pc", out_pc, 32'hffff_ffff ^ out_pc);
                end else begin
                    logic [63:0] e;
                    e = exp_dlv_q.pop_front();
                    check("dlv_pc", out_pc, e[63:32]);
                    check("dlv_inst", out_inst, e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        in_mem_flag = 1'b0;
        in_rob_xbp  = 1'b0;
    endtask

    task automatic expect_req(input logic [31:0] a);
        exp_req_q.push_back(a);
        n_req_exp++;
    endtask

    task automatic expect_dlv(input logic [31:0] p, input logic [31:0] d);
        exp_dlv_q.push_back({p, d});
        n_dlv_exp++;
    endtask

    // Bounded wait for all queued requests to have appeared.
    task automatic wait_req(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        #1;
        while (req_cnt < n_req_exp && n < 30) begin
            tick();
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, 32'(req_cnt), 32'(n_req_exp));
    endtask

    task automatic respond(input logic [31:0] d, input logic stall_val);
        in_stall    = stall_val;
        in_mem_flag = 1'b1;
        in_mem_data = d;
        tick();
    endtask

    task automatic flush(input logic [31:0] p, input logic stall_val);
        in_rob_xbp   = 1'b1;
        in_rob_newpc = p;
        in_stall     = stall_val;
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_mem_flag", 32'(out_mem_flag), 32'd0);
        check("rst_mem_addr", out_mem_addr, 32'd0);
        check("rst_inst_valid", 32'(out_inst_valid), 32'd0);
        check("rst_inst", out_inst, 32'd0);
        check("rst_pc", out_pc, 32'd0);

        // Cold start: request 0, deliver, then fill 0x4 and 0x8
        expect_req(32'h0);
        rst = 1'b0;
        in_stall = 1'b0;
        wait_req("cold_req0");
        expect_dlv(32'h0, DA);
        expect_req(32'h4);
        respond(DA, 1'b0);
        wait_req("cold_req4");
        expect_dlv(32'h4, DB);
        expect_req(32'h8);
        respond(DB, 1'b0);
        wait_req("fill_req8");
        expect_dlv(32'h8, DC);
        respond(DC, 1'b0);
        in_stall = 1'b1;
        tick();
        tick();
        check("fill_dlv_cnt", 32'(dlv_cnt), 32'(n_dlv_exp));

        // Hit path: three consecutive hits, no requests
        expect_dlv(32'h0, DA);
        expect_dlv(32'h4, DB);
        expect_dlv(32'h8, DC);
        flush(32'h0, 1'b0);
        tick();
        tick();
        tick();
        in_stall = 1'b1;
        @(negedge clk);
        #1;
        check("hit_dlv_cnt", 32'(dlv_cnt), 32'(n_dlv_exp));
        check("hit_no_req", 32'(req_cnt), 32'(n_req_exp));

        // Conflict: 0x200 evicts 0x000 (fill only, stalled at response)
        expect_req(32'h200);
        flush(32'h200, 1'b0);
        wait_req("conflict_req200");
        respond(DD, 1'b1);
        tick();
        check("stall_fill_no_dlv", 32'(dlv_cnt), 32'(n_dlv_exp));
        expect_req(32'h0);
        expect_dlv(32'h0, DA);
        flush(32'h0, 1'b0);
        wait_req("conflict_req0");
        respond(DA, 1'b0);
        in_stall = 1'b1;
        tick();

        // Stall at response: delivered later as a hit
        expect_req(32'h20);
        flush(32'h20, 1'b0);
        wait_req("stall_req20");
        respond(DE, 1'b1);
        tick();
        check("stall_resp_no_dlv", 32'(dlv_cnt), 32'(n_dlv_exp));
        expect_dlv(32'h20, DE);
        in_stall = 1'b0;
        tick();
        in_stall = 1'b1;
        @(negedge clk);
        #1;
        check("stall_hit_dlv", 32'(dlv_cnt), 32'(n_dlv_exp));
        check("stall_no_req", 32'(req_cnt), 32'(n_req_exp));

        // Flush during miss with a stray response afterwards
        expect_req(32'h10);
        flush(32'h10, 1'b0);
        wait_req("flush_req10");
        tick();
        tick();
        check("miss_addr_hold", out_mem_addr, 32'h10);
        check("miss_flag_pulse", 32'(out_mem_flag), 32'd0);
        expect_req(32'h40);
        flush(32'h40, 1'b0);
        in_mem_flag = 1'b1;
        in_mem_data = 32'hdeadbeef;
        tick();
        wait_req("flush_req40");
        check("flush_no_dlv", 32'(dlv_cnt), 32'(n_dlv_exp));
        expect_dlv(32'h40, DF);
        respond(DF, 1'b0);
        in_stall = 1'b1;
        tick();

        // rdy low for 5 cycles mid-miss
        expect_req(32'h60);
        flush(32'h60, 1'b0);
        wait_req("rdy_req60");
        rdy = 1'b0;
        repeat (5) begin
            tick();
            check("hold_mem_flag", 32'(out_mem_flag), 32'd1);
            check("hold_mem_addr", out_mem_addr, 32'h60);
            check("hold_inst_valid", 32'(out_inst_valid), 32'd0);
            check("hold_inst", out_inst, DF);
            check("hold_pc", out_pc, 32'h40);
        end
        rdy = 1'b1;
        expect_dlv(32'h60, DG);
        respond(DG, 1'b0);
        in_stall = 1'b1;
        tick();
        check("rdy_resume_dlv", 32'(dlv_cnt), 32'(n_dlv_exp));
        check("rdy_resume_no_req", 32'(req_cnt), 32'(n_req_exp));

        // Reset mid-miss: abandoned, next request to 0 (valid bits cleared)
        expect_req(32'h80);
        flush(32'h80, 1'b0);
        wait_req("rst_req80");
        rst = 1'b1;
        #1;
        check("rst_async_flag", 32'(out_mem_flag), 32'd0);
        check("rst_async_addr", out_mem_addr, 32'd0);
        check("rst_async_pc", out_pc, 32'd0);
        check("rst_async_inst", out_inst, 32'd0);
        tick();
        expect_req(32'h0);
        rst = 1'b0;
        wait_req("rst_req0");
        expect_dlv(32'h0, DH);
        respond(DH, 1'b0);
        in_stall = 1'b1;
        tick();
        tick();

        check("req_queue_empty", 32'(exp_req_q.size()), 32'd0);
        check("dlv_queue_empty", 32'(exp_dlv_q.size()), 32'd0);
        check("final_dlv_cnt", 32'(dlv_cnt), 32'(n_dlv_exp));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
